// File: rtl/io_stream_adapter_if.sv
// Stream bundle between the pad side, the adapter and the core side.
// slave  : the adapter's view (consumes pad-in and core-tx, produces core-rx and pad-out)
// master : the surrounding logic's view
interface io_stream_adapter_if #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 8,
  parameter int WORD_W = 32
) ();

  // pad input beats
  logic              in_vld;
  logic              in_rdy;
  logic [IN_W-1:0]   in_data;

  // packed words towards the core
  logic              core_rx_vld;
  logic              core_rx_rdy;
  logic [WORD_W-1:0] core_rx_data;

  // core words to serialise
  logic              core_tx_vld;
  logic              core_tx_rdy;
  logic [WORD_W-1:0] core_tx_data;

  // pad output beats
  logic              out_vld;
  logic              out_rdy;
  logic [OUT_W-1:0]  out_data;

  modport slave (
    input  in_vld, in_data,
    output in_rdy,
    output core_rx_vld, core_rx_data,
    input  core_rx_rdy,
    input  core_tx_vld, core_tx_data,
    output core_tx_rdy,
    output out_vld, out_data,
    input  out_rdy
  );

  modport master (
    output in_vld, in_data,
    input  in_rdy,
    input  core_rx_vld, core_rx_data,
    output core_rx_rdy,
    output core_tx_vld, core_tx_data,
    input  core_tx_rdy,
    input  out_vld, out_data,
    output out_rdy
  );

endinterface

// File: rtl/io_stream_adapter.sv
// Pad-to-core stream adapter.
// RX: packs IN_W pad beats into WORD_W words and queues them in a DEPTH-entry FIFO.
// TX: queues WORD_W core words in a DEPTH-entry FIFO and serialises them into OUT_W pad beats.
// Optional macro IO_STREAM_STATS_EN adds rx_word_cnt / tx_word_cnt word counters.
module io_stream_adapter #(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 8,
  parameter int WORD_W    = 32,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  io_stream_adapter_if.slave bus
`ifdef IO_STREAM_STATS_EN
  ,
  output logic [15:0]        rx_word_cnt,
  output logic [15:0]        tx_word_cnt
`endif
);

  localparam int RIN   = WORD_W / IN_W;
  localparam int ROUT  = WORD_W / OUT_W;
  localparam int RCW   = (RIN  > 1) ? $clog2(RIN)  : 1;
  localparam int TCW   = (ROUT > 1) ? $clog2(ROUT) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [RCW-1:0]    RX_LAST  = RCW'(RIN - 1);
  localparam logic [TCW-1:0]    TX_LAST  = TCW'(ROUT - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [WORD_W-1:0] IN_MASK  = WORD_W'({IN_W{1'b1}});

  // Configuration checks evaluated at elaboration
  if (((WORD_W % IN_W) != 0) || ((WORD_W % OUT_W) != 0)) begin : g_width_err
    $error("io_stream_adapter: WORD_W must be a multiple of IN_W and OUT_W");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_err
    $error("io_stream_adapter: DEPTH must be a power of two >= 2");
  end

  typedef enum logic [0:0] {
    TX_IDLE,
    TX_SHIFT
  } tx_state_t;

  // ---------------------------------------------------------------------------
  // RX pack
  // ---------------------------------------------------------------------------
  logic [RCW-1:0]    rx_cnt;
  logic [WORD_W-1:0] pack_q;
  logic [WORD_W-1:0] rx_word;
  int                rx_slot;
  logic              rx_last;
  logic              in_fire;
  logic              rx_push;
  logic              rx_pop;

  logic [WORD_W-1:0] rx_mem [DEPTH];
  logic [PTR_W-1:0]  rx_wptr;
  logic [PTR_W-1:0]  rx_rptr;
  logic [CNT_W-1:0]  rx_count;
  logic              rx_full;
  logic              rx_empty;

  assign rx_full  = (rx_count == FULL_CNT);
  assign rx_empty = (rx_count == '0);
  assign rx_last  = (rx_cnt == RX_LAST);

  // Ready only looks at registered state, so there is no pad-in to pad-in path
  assign bus.in_rdy = rst_n & (~rx_last | ~rx_full);
  assign in_fire    = bus.in_vld & bus.in_rdy;
  assign rx_push    = in_fire & rx_last;
  assign rx_pop     = bus.core_rx_vld & bus.core_rx_rdy;

  assign bus.core_rx_vld  = ~rx_empty;
  assign bus.core_rx_data = rx_mem[rx_rptr];

  // Merge the incoming beat into its slice; on the last beat this is the complete word
  always_comb begin
    rx_slot = (MSB_FIRST != 0) ? (RIN - 1 - int'(rx_cnt)) : int'(rx_cnt);
    rx_word = (pack_q & ~(IN_MASK << (rx_slot * IN_W)))
            | (WORD_W'(bus.in_data) << (rx_slot * IN_W));
  end

  // Beat counter and partial word register
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rx_cnt <= '0;
      pack_q <= '0;
    end else if (in_fire) begin
      pack_q <= rx_word;
      rx_cnt <= rx_last ? '0 : rx_cnt + RCW'(1);
    end
  end

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (rx_push && rst_n && !flush) begin
      rx_mem[rx_wptr] <= rx_word;
    end
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) begin
        rx_wptr <= rx_wptr + PTR_W'(1);
      end
      if (rx_pop) begin
        rx_rptr <= rx_rptr + PTR_W'(1);
      end
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + CNT_W'(1);
        2'b01:   rx_count <= rx_count - CNT_W'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0] tx_mem [DEPTH];
  logic [PTR_W-1:0]  tx_wptr;
  logic [PTR_W-1:0]  tx_rptr;
  logic [CNT_W-1:0]  tx_count;
  logic              tx_full;
  logic              tx_empty;
  logic              tx_push;
  logic              tx_pop;
  logic [WORD_W-1:0] tx_head;

  assign tx_full  = (tx_count == FULL_CNT);
  assign tx_empty = (tx_count == '0);
  assign tx_head  = tx_mem[tx_rptr];

  assign bus.core_tx_rdy = rst_n & ~tx_full;
  assign tx_push         = bus.core_tx_vld & bus.core_tx_rdy;

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (tx_push && rst_n && !flush) begin
      tx_mem[tx_wptr] <= bus.core_tx_data;
    end
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) begin
        tx_wptr <= tx_wptr + PTR_W'(1);
      end
      if (tx_pop) begin
        tx_rptr <= tx_rptr + PTR_W'(1);
      end
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + CNT_W'(1);
        2'b01:   tx_count <= tx_count - CNT_W'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // TX serialiser
  // ---------------------------------------------------------------------------
  tx_state_t         tx_state;
  logic [WORD_W-1:0] tx_shift;
  logic [TCW-1:0]    tx_cnt;
  logic              out_vld_q;
  logic [OUT_W-1:0]  out_data_q;
  logic              tx_last_beat;

  function automatic logic [OUT_W-1:0] beat_of(input logic [WORD_W-1:0] w,
                                               input logic [TCW-1:0]    idx);
    int                slot;
    logic [WORD_W-1:0] s;
    slot = (MSB_FIRST != 0) ? (ROUT - 1 - int'(idx)) : int'(idx);
    s    = w >> (slot * OUT_W);
    return s[OUT_W-1:0];
  endfunction

  // In SHIFT the output is always valid, so out_rdy alone completes a beat
  assign tx_last_beat = (tx_state == TX_SHIFT) & bus.out_rdy & (tx_cnt == TX_LAST);
  assign tx_pop       = ~tx_empty & ((tx_state == TX_IDLE) | tx_last_beat);

  assign bus.out_vld  = out_vld_q;
  assign bus.out_data = out_data_q;

  // Serialiser FSM; the next beat is precomputed so pad outputs come straight from flops
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      tx_state   <= TX_IDLE;
      tx_shift   <= '0;
      tx_cnt     <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (!tx_empty) begin
            tx_shift   <= tx_head;
            tx_cnt     <= '0;
            out_vld_q  <= 1'b1;
            out_data_q <= beat_of(tx_head, TCW'(0));
            tx_state   <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          if (bus.out_rdy) begin
            if (tx_cnt != TX_LAST) begin
              tx_cnt     <= tx_cnt + TCW'(1);
              out_data_q <= beat_of(tx_shift, tx_cnt + TCW'(1));
            end else if (!tx_empty) begin
              tx_shift   <= tx_head;
              tx_cnt     <= '0;
              out_data_q <= beat_of(tx_head, TCW'(0));
            end else begin
              out_vld_q <= 1'b0;
              tx_state  <= TX_IDLE;
            end
          end
        end
        default: begin
          out_vld_q <= 1'b0;
          tx_state  <= TX_IDLE;
        end
      endcase
    end
  end

`ifdef IO_STREAM_STATS_EN
  // Word counters: RX counts FIFO pushes, TX counts words whose last beat left the pad
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rx_word_cnt <= '0;
      tx_word_cnt <= '0;
    end else begin
      if (rx_push) begin
        rx_word_cnt <= rx_word_cnt + 16'd1;
      end
      if (tx_last_beat) begin
        tx_word_cnt <= tx_word_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_io_stream_adapter.sv
// Bench for io_stream_adapter: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_io_stream_adapter;

  localparam int IN_W   = 16;
  localparam int OUT_W  = 8;
  localparam int WORD_W = 32;
  localparam int DEPTH  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  io_stream_adapter_if #(.IN_W(IN_W), .OUT_W(OUT_W), .WORD_W(WORD_W)) bus   ();
  io_stream_adapter_if #(.IN_W(IN_W), .OUT_W(OUT_W), .WORD_W(WORD_W)) bus_m ();

`ifdef IO_STREAM_STATS_EN
  logic [15:0] rx_wc, tx_wc, rx_wc_m, tx_wc_m;
`endif

  io_stream_adapter #(
    .IN_W(IN_W), .OUT_W(OUT_W), .WORD_W(WORD_W), .DEPTH(DEPTH), .MSB_FIRST(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus(bus)
`ifdef IO_STREAM_STATS_EN
    ,
    .rx_word_cnt(rx_wc),
    .tx_word_cnt(tx_wc)
`endif
  );

  io_stream_adapter #(
    .IN_W(IN_W), .OUT_W(OUT_W), .WORD_W(WORD_W), .DEPTH(DEPTH), .MSB_FIRST(1)
  ) dut_m (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus(bus_m)
`ifdef IO_STREAM_STATS_EN
    ,
    .rx_word_cnt(rx_wc_m),
    .tx_word_cnt(tx_wc_m)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (MSB_FIRST=0 instance): words and beats as queues
  // ---------------------------------------------------------------------------
  logic [31:0] m_rx_q[$];
  logic [31:0] m_tx_q[$];
  logic [7:0]  m_beats[$];
  int          m_pk_n = 0;
  logic [15:0] m_pk_lo = '0;
  bit          m_ok = 0;

  always @(posedge clk) begin
    bit          in_rdy_e, tx_rdy_e, have_word, active;
    logic [31:0] w;
    if (!rst_n || flush) begin
      m_rx_q.delete();
      m_tx_q.delete();
      m_beats.delete();
      m_pk_n = 0;
      if (!rst_n) m_ok = 1;
    end else begin
      in_rdy_e  = (m_pk_n != 1) || (m_rx_q.size() < DEPTH);
      tx_rdy_e  = (m_tx_q.size() < DEPTH);
      have_word = (m_tx_q.size() > 0);
      active    = (m_beats.size() > 0);
      if (bus.core_rx_rdy && m_rx_q.size() > 0) void'(m_rx_q.pop_front());
      if (bus.in_vld && in_rdy_e) begin
        if (m_pk_n == 1) begin
          m_rx_q.push_back({bus.in_data, m_pk_lo});
          m_pk_n = 0;
        end else begin
          m_pk_lo = bus.in_data;
          m_pk_n  = 1;
        end
      end
      if (active && bus.out_rdy) void'(m_beats.pop_front());
      if (have_word && m_beats.size() == 0) begin
        w = m_tx_q.pop_front();
        for (int k = 0; k < 4; k++) m_beats.push_back(w[8*k +: 8]);
      end
      if (bus.core_tx_vld && tx_rdy_e) m_tx_q.push_back(bus.core_tx_data);
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_ok) begin
      chk("in_rdy", 32'(bus.in_rdy),
          rst_n ? 32'((m_pk_n != 1) || (m_rx_q.size() < DEPTH)) : 32'd0);
      chk("core_rx_vld", 32'(bus.core_rx_vld), 32'(m_rx_q.size() > 0));
      if (m_rx_q.size() > 0) chk("core_rx_data", bus.core_rx_data, m_rx_q[0]);
      chk("core_tx_rdy", 32'(bus.core_tx_rdy),
          rst_n ? 32'(m_tx_q.size() < DEPTH) : 32'd0);
      chk("out_vld", 32'(bus.out_vld), 32'(m_beats.size() > 0));
      if (m_beats.size() > 0) chk("out_data", 32'(bus.out_data), 32'(m_beats[0]));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    bit          pat[7] = '{1, 0, 0, 1, 1, 1, 1};
    logic [31:0] acc;
    logic [63:0] acc64;
    logic [31:0] last;
    logic [7:0]  prev;
    logic        pv;
    int          n, gaps;

    bus.in_vld = 0; bus.in_data = '0; bus.core_rx_rdy = 0;
    bus.core_tx_vld = 0; bus.core_tx_data = '0; bus.out_rdy = 0;
    bus_m.in_vld = 0; bus_m.in_data = '0; bus_m.core_rx_rdy = 0;
    bus_m.core_tx_vld = 0; bus_m.core_tx_data = '0; bus_m.out_rdy = 0;

    // Reset
    rst_n = 0;
    tick();
    chk("rst_in_rdy_low", 32'(bus.in_rdy), 32'd0);
    tick();
    rst_n = 1;
    #1;
    chk("rst_in_rdy", 32'(bus.in_rdy), 32'd1);
    chk("rst_core_rx_vld", 32'(bus.core_rx_vld), 32'd0);
    chk("rst_core_tx_rdy", 32'(bus.core_tx_rdy), 32'd1);
    chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);

    // 1: two beats pack into one word, both orderings
    bus.in_vld = 1; bus.in_data = 16'h1111;
    bus_m.in_vld = 1; bus_m.in_data = 16'h1111;
    tick();
    chk("t1_rx_vld_mid", 32'(bus.core_rx_vld), 32'd0);
    bus.in_data = 16'h2222; bus_m.in_data = 16'h2222;
    tick();
    bus.in_vld = 0; bus_m.in_vld = 0;
    chk("t1_rx_vld", 32'(bus.core_rx_vld), 32'd1);
    chk("t1_rx_data", bus.core_rx_data, 32'h22221111);
    chk("t1_msb_rx_data", bus_m.core_rx_data, 32'h11112222);
    bus.core_rx_rdy = 1; bus_m.core_rx_rdy = 1;
    tick();
    bus.core_rx_rdy = 0; bus_m.core_rx_rdy = 0;
    chk("t1_rx_vld_popped", 32'(bus.core_rx_vld), 32'd0);
    bus_m.core_tx_vld = 1; bus_m.core_tx_data = 32'hA1B2C3D4; bus_m.out_rdy = 1;
    tick();
    bus_m.core_tx_vld = 0;
    acc = '0; n = 0;
    for (int i = 0; i < 10 && n < 4; i++) begin
      if (bus_m.out_vld) begin
        acc = {acc[23:0], bus_m.out_data};
        n++;
      end
      tick();
    end
    chk("t1_msb_tx_beats", acc, 32'hA1B2C3D4);
    chk("t1_msb_tx_count", 32'(n), 32'd4);

    // 2: fill RX FIFO with core stalled, then free one slot
    bus.in_vld = 1;
    for (int i = 0; i < 9; i++) begin
      bus.in_data = 16'(i + 1);
      chk("t2_in_rdy", 32'(bus.in_rdy), 32'd1);
      tick();
    end
    bus.in_data = 16'h000A;
    chk("t2_in_rdy_full", 32'(bus.in_rdy), 32'd0);
    tick();
    chk("t2_in_rdy_held", 32'(bus.in_rdy), 32'd0);
    chk("t2_head", bus.core_rx_data, 32'h00020001);
    bus.core_rx_rdy = 1;
    tick();
    bus.core_rx_rdy = 0;
    chk("t2_in_rdy_freed", 32'(bus.in_rdy), 32'd1);
    tick();
    bus.in_vld = 0;
    bus.core_rx_rdy = 1;
    n = 0; last = '0;
    for (int i = 0; i < 8 && bus.core_rx_vld; i++) begin
      last = bus.core_rx_data;
      n++;
      tick();
    end
    bus.core_rx_rdy = 0;
    chk("t2_last_word", last, 32'h000A0009);
    chk("t2_drained", 32'(n), 32'd4);

    // 3: two words serialised back to back
    bus.out_rdy = 1;
    bus.core_tx_vld = 1; bus.core_tx_data = 32'hA1B2C3D4;
    tick();
    chk("t3_out_vld_early", 32'(bus.out_vld), 32'd0);
    bus.core_tx_data = 32'h01020304;
    tick();
    bus.core_tx_vld = 0;
    chk("t3_first_vld", 32'(bus.out_vld), 32'd1);
    chk("t3_first_data", 32'(bus.out_data), 32'h000000D4);
    acc64 = '0; n = 0; gaps = 0;
    for (int i = 0; i < 20 && n < 8; i++) begin
      if (bus.out_vld) begin
        acc64 = {acc64[55:0], bus.out_data};
        n++;
      end else if (n > 0) begin
        gaps++;
      end
      tick();
    end
    chk("t3_beats_hi", acc64[63:32], 32'hD4C3B2A1);
    chk("t3_beats_lo", acc64[31:0], 32'h04030201);
    chk("t3_gaps", 32'(gaps), 32'd0);

    // 4: backpressure during a word
    bus.core_tx_vld = 1; bus.core_tx_data = 32'h44332211;
    tick();
    bus.core_tx_vld = 0;
    tick();
    acc = '0; n = 0;
    for (int i = 0; i < 7; i++) begin
      bus.out_rdy = pat[i];
      prev = bus.out_data;
      pv = bus.out_vld;
      if (bus.out_vld && pat[i]) begin
        acc = {bus.out_data, acc[31:8]};
        n++;
      end
      tick();
      if (!pat[i]) begin
        chk("t4_hold_data", 32'(bus.out_data), 32'(prev));
        chk("t4_hold_vld", 32'(bus.out_vld), 32'(pv));
      end
    end
    chk("t4_beats", acc, 32'h44332211);
    chk("t4_count", 32'(n), 32'd4);
    bus.out_rdy = 1;

    // 5: flush clears partial pack, queued words and a stalled TX word
    bus.out_rdy = 0;
    bus.core_tx_vld = 1; bus.core_tx_data = 32'hDEADBEEF;
    bus.in_vld = 1; bus.in_data = 16'h5555;
    tick();
    bus.core_tx_vld = 0; bus.in_vld = 0;
    tick();
    chk("t5_inflight_vld", 32'(bus.out_vld), 32'd1);
`ifdef IO_STREAM_STATS_EN
    chk("t5_rx_wc_before", 32'(rx_wc), 32'd6);
    chk("t5_tx_wc_before", 32'(tx_wc), 32'd3);
`endif
    flush = 1;
    bus.in_vld = 1; bus.in_data = 16'h7777;
    tick();
    flush = 0; bus.in_vld = 0;
    chk("t5_out_vld", 32'(bus.out_vld), 32'd0);
    chk("t5_out_data", 32'(bus.out_data), 32'd0);
    chk("t5_rx_vld", 32'(bus.core_rx_vld), 32'd0);
    chk("t5_tx_rdy", 32'(bus.core_tx_rdy), 32'd1);
`ifdef IO_STREAM_STATS_EN
    chk("t5_rx_wc", 32'(rx_wc), 32'd0);
    chk("t5_tx_wc", 32'(tx_wc), 32'd0);
`endif
    bus.in_vld = 1; bus.in_data = 16'h3333;
    tick();
    bus.in_data = 16'h4444;
    tick();
    bus.in_vld = 0;
    chk("t5_rx_data", bus.core_rx_data, 32'h44443333);
    bus.core_rx_rdy = 1;
    tick();
    bus.core_rx_rdy = 0;

    // 6: reset in the middle of serialising
    bus.out_rdy = 1;
    bus.core_tx_vld = 1; bus.core_tx_data = 32'h0BADF00D;
    tick();
    bus.core_tx_vld = 0;
    tick();
    tick();
    chk("t6_mid_vld", 32'(bus.out_vld), 32'd1);
    chk("t6_mid_data", 32'(bus.out_data), 32'h000000F0);
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    chk("t6_out_vld", 32'(bus.out_vld), 32'd0);
    chk("t6_rx_vld", 32'(bus.core_rx_vld), 32'd0);
    chk("t6_tx_rdy", 32'(bus.core_tx_rdy), 32'd1);
    chk("t6_in_rdy", 32'(bus.in_rdy), 32'd1);
    bus.core_tx_vld = 1; bus.core_tx_data = 32'hCAFEF00D;
    bus.in_vld = 1; bus.in_data = 16'hBEEF;
    tick();
    bus.core_tx_vld = 0;
    bus.in_data = 16'h1234;
    tick();
    bus.in_vld = 0;
    chk("t6_rx_data", bus.core_rx_data, 32'h1234BEEF);
    acc = '0; n = 0;
    for (int i = 0; i < 10 && n < 4; i++) begin
      if (bus.out_vld) begin
        acc = {bus.out_data, acc[31:8]};
        n++;
      end
      tick();
    end
    chk("t6_tx_beats", acc, 32'hCAFEF00D);
    chk("t6_tx_count", 32'(n), 32'd4);
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/io_stream_adapter.md
Name: io_stream_adapter

Overview:
Parametrised pad-to-core stream adapter that replaces fixed-width pad wiring. RX path: packs narrow pad beats into core words and buffers them in a FIFO. TX path: buffers core words in a FIFO and serialises them into narrow pad beats. It sits between the GPIO pad assignments in the user project wrapper and the accelerator's valid/ready stream ports.

Parameters:
IN_W, 16, pad input beat width (bits)
OUT_W, 8, pad output beat width (bits)
WORD_W, 32, core word width; integer multiple of both IN_W and OUT_W
DEPTH, 4, entries per FIFO (RX and TX); power of two, >= 2
MSB_FIRST, 0, 0 = first beat maps to word LSBs; 1 = first beat maps to word MSBs (both paths)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  synchronous clear of both paths, including partial pack/serialise state
in_vld  in  1  pad input beat valid
in_rdy  out  1  pad input beat ready
in_data  in  IN_W  pad input beat
core_rx_vld  out  1  packed word available
core_rx_rdy  in  1  core accepts packed word
core_rx_data  out  WORD_W  packed word (RX FIFO head)
core_tx_vld  in  1  core word valid
core_tx_rdy  out  1  TX FIFO can accept
core_tx_data  in  WORD_W  core word to send
out_vld  out  1  pad output beat valid
out_rdy  in  1  pad receiver ready
out_data  out  OUT_W  pad output beat

Behaviour:
- Reset (rst_n=0 at edge) or flush=1: FIFOs empty, pack/serialise counters 0, TX FSM IDLE. Outputs: in_rdy=0 during reset cycle then 1; core_rx_vld=0; core_tx_rdy=1 after reset; out_vld=0; out_data=0. Reset takes priority over flush. Flush takes priority over any same-cycle transfer, which is discarded.
- Transfer occurs on an edge where vld&rdy=1 for that interface. vld must not depend on rdy. Once vld is asserted, data is held until the transfer completes.
- RX pack:
  - RIN=WORD_W/IN_W. Beat counter rx_cnt runs 0..RIN-1 and wraps.
  - Beat k fills slice k (MSB_FIRST=0) or slice RIN-1-k (MSB_FIRST=1) of the pack register.
  - On beat rx_cnt=RIN-1, the full word (last slice taken directly from in_data) is written into the RX FIFO the same edge.
  - in_rdy = (rx_cnt != RIN-1) | !rx_full. It uses registered FIFO state only; a same-cycle pop does not free space. No combinational pad-to-pad path.
- FIFOs:
  - Registered count. A word written at edge N gives core_rx_vld=1 after edge N.
  - Simultaneous push and pop when not full/empty: count unchanged, order preserved. Pointers wrap modulo DEPTH.
  - core_tx_rdy = !tx_full (registered).
- TX serialiser FSM:
  - ROUT=WORD_W/OUT_W.
  - IDLE: if TX FIFO non-empty, pop the head into the shift register, tx_cnt=0, go to SHIFT; out_vld=1 from the next cycle.
  - SHIFT: out_data = slice tx_cnt (or ROUT-1-tx_cnt when MSB_FIRST=1) of the shift register. On out_vld&out_rdy with tx_cnt<ROUT-1: tx_cnt++.
  - On the last beat accepted: if the FIFO is non-empty, pop and reload the same edge, tx_cnt=0, stay in SHIFT (no bubble); else go to IDLE, out_vld=0.
  - With out_rdy=0, out_data and out_vld are held.
- Latency: core word to first pad beat = 2 cycles from an empty TX path. Last input beat to core_rx_vld = 1 cycle.
- Width rule: WORD_W%IN_W or WORD_W%OUT_W != 0 is a configuration error, flagged by an elaboration-time check.

Optional Feature:
Macro IO_STREAM_STATS_EN.
- Defined: adds outputs rx_word_cnt [15:0] and tx_word_cnt [15:0].
  - rx_word_cnt counts words pushed into the RX FIFO; tx_word_cnt counts words whose last beat left the pad.
  - Both wrap 0xFFFF->0 and clear on reset or flush.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. Defaults: in_data 0x1111 then 0x2222 -> core_rx_vld rises the cycle after the second beat, core_rx_data=0x22221111. With MSB_FIRST=1 -> 0x11112222.
2. core_rx_rdy=0, stream 9 beats -> 4 words buffered, 9th beat accepted into the pack register, in_rdy=0 on the 10th beat. One core pop -> in_rdy=1 on the next cycle.
3. Push 0xA1B2C3D4 then 0x01020304 with out_rdy=1 -> out_data D4,C3,B2,A1,04,03,02,01 on 8 consecutive out_vld cycles, first beat 2 cycles after the push.
4. out_rdy toggling 1,0,0,1 during a word -> out_data held stable while stalled, no beat lost or duplicated.
5. One beat 0x5555, then flush=1, then 0x3333,0x4444 -> core_rx_data=0x44443333. TX beats in flight are dropped, out_vld=0 after the flush edge. With the stats macro defined, both counters read 0 after the flush edge.
6. rst_n=0 mid-serialise for 1 cycle -> after release: out_vld=0, core_rx_vld=0, FIFOs empty, normal operation on the next transfer.
